// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic array activation feeder.
//   N         : default array dimension (tile rows/cols, datain lanes)
//   DW        : default element width in bits
//   state_t   : feeder state (LOAD collects rows, STREAM emits diagonals)
//   first_row : index of the first tile row touched by anti-diagonal k
// -----------------------------------------------------------------------------
package systolic_pkg;

    localparam int N  = 4;
    localparam int DW = 8;

    typedef enum logic {
        LOAD   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Anti-diagonal k starts at row max(0, k-n+1).
    function automatic int first_row(input int k, input int n);
        return (k > n - 1) ? (k - n + 1) : 0;
    endfunction

endpackage

// File: rtl/diag_select.sv
// -----------------------------------------------------------------------------
// diag_select
// Combinational picker for one anti-diagonal beat of a buffered N x N tile.
//   tile : buffered tile, tile[row][col]
//   k    : anti-diagonal index, 0 .. 2N-2
//   beat : packed beat, slot 0 in the MSB element; slot s carries
//          tile[r][k-r] with r = first_row(k) + s, or 0 past the diagonal end
// -----------------------------------------------------------------------------
module diag_select #(
    parameter int N  = systolic_pkg::N,
    parameter int DW = systolic_pkg::DW,
    parameter int KW = $clog2(2 * N - 1)
) (
    input  logic [DW-1:0]   tile [N][N],
    input  logic [KW-1:0]   k,
    output logic [N*DW-1:0] beat
);
    import systolic_pkg::*;

    localparam int RW = (N > 1) ? $clog2(N) : 1;

    int r;
    int c;
    int kk;

    always_comb begin
        beat = '0;
        r    = 0;
        c    = 0;
        kk   = int'(k);
        for (int s = 0; s < N; s++) begin
            r = first_row(kk, N) + s;
            c = kk - r;
            // r <= k keeps the column index non-negative on the short
            // leading diagonals; r <= N-1 bounds the trailing ones.
            if (r <= N - 1 && r <= kk) begin
                beat[(N-1-s)*DW +: DW] = tile[r[RW-1:0]][c[RW-1:0]];
            end
        end
    end

endmodule

// File: rtl/systolic_diag_feeder.sv
// -----------------------------------------------------------------------------
// systolic_diag_feeder
// Collects an N x N activation tile as N row beats, then drives it onto the
// systolic array's datain bus as 2N-1 anti-diagonal beats with no stalls.
// Ports:
//   clk       : clock, all state on rising edge
//   reset     : asynchronous active-low reset
//   row_in    : one tile row, column 0 in the MSB element slot
//   row_valid : row_in valid
//   row_ready : feeder accepts a row this cycle (high throughout LOAD)
//   datain    : registered anti-diagonal beat, zero when not streaming
//   out_valid : datain carries a tile beat
//   out_first : beat 0 of a tile
//   out_last  : beat 2N-2 of a tile
//   busy      : streaming, or at least one row of a tile accepted
// Handshake: a row transfers on a rising edge where row_valid && row_ready;
// row_ready does not depend on row_valid. Designed for N >= 2.
// -----------------------------------------------------------------------------
module systolic_diag_feeder #(
    parameter int N  = systolic_pkg::N,
    parameter int DW = systolic_pkg::DW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N*DW-1:0] row_in,
    input  logic            row_valid,
    output logic            row_ready,
    output logic [N*DW-1:0] datain,
    output logic            out_valid,
    output logic            out_first,
    output logic            out_last,
    output logic            busy
);
    import systolic_pkg::*;

    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = $clog2(2 * N - 1);
    localparam logic [RW-1:0] ROW_LAST    = RW'(N - 1);
    localparam logic [KW-1:0] BEAT_LAST   = KW'(2 * N - 2);
    localparam logic [KW-1:0] BEAT_PENULT = KW'(2 * N - 3);

    state_t          state, state_nxt;
    logic [RW-1:0]   row_cnt, row_cnt_nxt;
    logic [KW-1:0]   beat_cnt, beat_cnt_nxt;
    logic [KW-1:0]   sel_k;
    logic            accept;
    logic [N*DW-1:0] beat;
    logic [N*DW-1:0] datain_nxt;
    logic            out_valid_nxt;
    logic            out_first_nxt;
    logic            out_last_nxt;
    logic [DW-1:0]   tile [N][N];

    diag_select #(
        .N  (N),
        .DW (DW),
        .KW (KW)
    ) u_diag_select (
        .tile (tile),
        .k    (sel_k),
        .beat (beat)
    );

    // The output register always holds the beat for the *current* cycle, so
    // the select index looks one beat ahead of beat_cnt. Beat 0 is loaded on
    // the edge that accepts the last row; it only needs tile[0][0], which is
    // already in the buffer at that point.
    always_comb begin
        state_nxt     = state;
        row_cnt_nxt   = row_cnt;
        beat_cnt_nxt  = beat_cnt;
        sel_k         = '0;
        out_valid_nxt = 1'b0;
        out_first_nxt = 1'b0;
        out_last_nxt  = 1'b0;
        row_ready     = (state == LOAD);
        accept        = row_ready && row_valid;

        case (state)
            LOAD: begin
                if (accept) begin
                    if (row_cnt == ROW_LAST) begin
                        row_cnt_nxt   = '0;
                        beat_cnt_nxt  = '0;
                        state_nxt     = STREAM;
                        out_valid_nxt = 1'b1;
                        out_first_nxt = 1'b1;
                    end else begin
                        row_cnt_nxt = row_cnt + 1'b1;
                    end
                end
            end
            STREAM: begin
                if (beat_cnt == BEAT_LAST) begin
                    beat_cnt_nxt = '0;
                    state_nxt    = LOAD;
                end else begin
                    beat_cnt_nxt  = beat_cnt + 1'b1;
                    sel_k         = beat_cnt + 1'b1;
                    out_valid_nxt = 1'b1;
                    out_last_nxt  = (beat_cnt == BEAT_PENULT);
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase

        datain_nxt = out_valid_nxt ? beat : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LOAD;
            row_cnt   <= '0;
            beat_cnt  <= '0;
            datain    <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            row_cnt   <= row_cnt_nxt;
            beat_cnt  <= beat_cnt_nxt;
            datain    <= datain_nxt;
            out_valid <= out_valid_nxt;
            out_first <= out_first_nxt;
            out_last  <= out_last_nxt;
        end
    end

    // Tile buffer: contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int col = 0; col < N; col++) begin
                tile[row_cnt][col] <= row_in[(N-1-col)*DW +: DW];
            end
        end
    end

    assign busy = (state == STREAM) || (row_cnt != '0);

endmodule

// File: tb/tb_systolic_diag_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_diag_feeder
// Directed bench for systolic_diag_feeder: an N=4/DW=8 instance driven from a
// per-cycle vector table plus hand sequences (gapped load, rows offered during
// stream, back-to-back tiles, reset mid-stream), and an N=2/DW=16 instance.
// -----------------------------------------------------------------------------
module tb_systolic_diag_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [31:0] a_row_in, a_datain;
    logic        a_row_valid, a_row_ready, a_out_valid, a_out_first, a_out_last, a_busy;
    logic [31:0] b_row_in, b_datain;
    logic        b_row_valid, b_row_ready, b_out_valid, b_out_first, b_out_last, b_busy;

    systolic_diag_feeder #(.N(4), .DW(8)) dut_a (
        .clk       (clk),
        .reset     (rst_n),
        .row_in    (a_row_in),
        .row_valid (a_row_valid),
        .row_ready (a_row_ready),
        .datain    (a_datain),
        .out_valid (a_out_valid),
        .out_first (a_out_first),
        .out_last  (a_out_last),
        .busy      (a_busy)
    );

    systolic_diag_feeder #(.N(2), .DW(16)) dut_b (
        .clk       (clk),
        .reset     (rst_n),
        .row_in    (b_row_in),
        .row_valid (b_row_valid),
        .row_ready (b_row_ready),
        .datain    (b_datain),
        .out_valid (b_out_valid),
        .out_first (b_out_first),
        .out_last  (b_out_last),
        .busy      (b_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef logic [31:0] beats_t [7];
    typedef logic [31:0] rows_t  [4];

    typedef struct packed {
        logic [31:0] rin;
        logic        rv;
        logic        e_ready;
        logic [31:0] e_data;
        logic        e_valid;
        logic        e_first;
        logic        e_last;
        logic        e_busy;
    } vec_t;

    vec_t   tbl [12];
    rows_t  rows_a, rows_11;
    beats_t beats_a, beats_11;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] rin, input logic rv, input logic rdy,
                                input logic [31:0] d, input logic v, input logic f,
                                input logic l, input logic b);
        vec_t t;
        t.rin = rin; t.rv = rv; t.e_ready = rdy; t.e_data = d;
        t.e_valid = v; t.e_first = f; t.e_last = l; t.e_busy = b;
        return t;
    endfunction

    task automatic load_row_a(input logic [31:0] r, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            a_row_valid = 1'b0;
            #1;
            chk("gap_out_valid", 32'(a_out_valid), 32'd0);
            chk("gap_row_ready", 32'(a_row_ready), 32'd1);
        end
        @(negedge clk);
        a_row_valid = 1'b1;
        a_row_in    = r;
        #1;
        chk("load_row_ready", 32'(a_row_ready), 32'd1);
        chk("load_out_valid", 32'(a_out_valid), 32'd0);
        chk("load_datain", a_datain, 32'd0);
    endtask

    task automatic load_tile_a(input rows_t rows, input int gap);
        for (int i = 0; i < 4; i++) load_row_a(rows[i], (i == 0) ? 0 : gap);
    endtask

    task automatic stream_a(input beats_t exp, input logic hold, input logic [31:0] junk);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            a_row_valid = hold;
            a_row_in    = junk;
            #1;
            chk($sformatf("beat%0d_datain", k), a_datain, exp[k]);
            chk($sformatf("beat%0d_out_valid", k), 32'(a_out_valid), 32'd1);
            chk($sformatf("beat%0d_out_first", k), 32'(a_out_first), (k == 0) ? 32'd1 : 32'd0);
            chk($sformatf("beat%0d_out_last", k), 32'(a_out_last), (k == 6) ? 32'd1 : 32'd0);
            chk($sformatf("beat%0d_row_ready", k), 32'(a_row_ready), 32'd0);
            chk($sformatf("beat%0d_busy", k), 32'(a_busy), 32'd1);
        end
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a_row_valid = 1'b0;
            #1;
            chk("idle_out_valid", 32'(a_out_valid), 32'd0);
            chk("idle_datain", a_datain, 32'd0);
            chk("idle_row_ready", 32'(a_row_ready), 32'd1);
        end
    endtask

    initial begin
        rows_a   = '{32'h01020407, 32'h0305080B, 32'h06090C0E, 32'h0A0D0F10};
        beats_a  = '{32'h01000000, 32'h02030000, 32'h04050600, 32'h0708090A,
                     32'h0B0C0D00, 32'h0E0F0000, 32'h10000000};
        rows_11  = '{32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111};
        beats_11 = '{32'h11000000, 32'h11110000, 32'h11111100, 32'h11111111,
                     32'h11111100, 32'h11110000, 32'h11000000};

        //          row_in        rv  rdy datain        v  f  l  busy
        tbl[0]  = mk(32'h01020407, 1, 1, 32'h00000000, 0, 0, 0, 0);
        tbl[1]  = mk(32'h0305080B, 1, 1, 32'h00000000, 0, 0, 0, 1);
        tbl[2]  = mk(32'h06090C0E, 1, 1, 32'h00000000, 0, 0, 0, 1);
        tbl[3]  = mk(32'h0A0D0F10, 1, 1, 32'h00000000, 0, 0, 0, 1);
        tbl[4]  = mk(32'h00000000, 0, 0, 32'h01000000, 1, 1, 0, 1);
        tbl[5]  = mk(32'h00000000, 0, 0, 32'h02030000, 1, 0, 0, 1);
        tbl[6]  = mk(32'h00000000, 0, 0, 32'h04050600, 1, 0, 0, 1);
        tbl[7]  = mk(32'h00000000, 0, 0, 32'h0708090A, 1, 0, 0, 1);
        tbl[8]  = mk(32'h00000000, 0, 0, 32'h0B0C0D00, 1, 0, 0, 1);
        tbl[9]  = mk(32'h00000000, 0, 0, 32'h0E0F0000, 1, 0, 0, 1);
        tbl[10] = mk(32'h00000000, 0, 0, 32'h10000000, 1, 0, 1, 1);
        tbl[11] = mk(32'h00000000, 0, 1, 32'h00000000, 0, 0, 0, 0);

        // Clock/reset
        rst_n       = 1'b0;
        a_row_in    = '0;
        a_row_valid = 1'b0;
        b_row_in    = '0;
        b_row_valid = 1'b0;
        #2;
        chk("rst_datain", a_datain, 32'd0);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_first", 32'(a_out_first), 32'd0);
        chk("rst_out_last", 32'(a_out_last), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_row_ready", 32'(a_row_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Baseline tile, row_valid held high, per-cycle table
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            a_row_valid = tbl[i].rv;
            a_row_in    = tbl[i].rin;
            #1;
            chk($sformatf("tbl%0d_row_ready", i), 32'(a_row_ready), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_datain", i), a_datain, tbl[i].e_data);
            chk($sformatf("tbl%0d_out_valid", i), 32'(a_out_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_out_first", i), 32'(a_out_first), 32'(tbl[i].e_first));
            chk($sformatf("tbl%0d_out_last", i), 32'(a_out_last), 32'(tbl[i].e_last));
            chk($sformatf("tbl%0d_busy", i), 32'(a_busy), 32'(tbl[i].e_busy));
        end

        // Gapped load: two idle cycles between rows, same beats
        load_tile_a(rows_a, 2);
        stream_a(beats_a, 1'b0, 32'h0);
        idle_a(2);

        // Rows offered during stream are refused; next tile loads back-to-back
        load_tile_a(rows_a, 0);
        stream_a(beats_a, 1'b1, 32'hFFFFFFFF);
        load_tile_a(rows_11, 0);
        stream_a(beats_11, 1'b0, 32'h0);
        idle_a(1);

        // Reset during beat 3: outputs clear at once, partial tile discarded
        load_tile_a(rows_a, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_row_valid = 1'b0;
            #1;
            chk($sformatf("pre_rst_beat%0d", k), a_datain, beats_a[k]);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_datain", a_datain, 32'd0);
        chk("midrst_out_valid", 32'(a_out_valid), 32'd0);
        chk("midrst_busy", 32'(a_busy), 32'd0);
        chk("midrst_row_ready", 32'(a_row_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        idle_a(3);
        load_row_a(rows_11[0], 0);
        load_row_a(rows_11[1], 0);
        idle_a(3);
        chk("partial_busy", 32'(a_busy), 32'd1);
        load_row_a(rows_11[2], 0);
        load_row_a(rows_11[3], 0);
        stream_a(beats_11, 1'b0, 32'h0);
        idle_a(1);

        // N=2, DW=16 instance
        @(negedge clk);
        b_row_valid = 1'b1;
        b_row_in    = 32'h00010002;
        #1;
        chk("b_row0_ready", 32'(b_row_ready), 32'd1);
        @(negedge clk);
        b_row_in = 32'h00030004;
        #1;
        chk("b_row1_ready", 32'(b_row_ready), 32'd1);
        chk("b_load_out_valid", 32'(b_out_valid), 32'd0);
        @(negedge clk);
        b_row_valid = 1'b0;
        #1;
        chk("b_beat0_datain", b_datain, 32'h00010000);
        chk("b_beat0_first", 32'(b_out_first), 32'd1);
        chk("b_beat0_valid", 32'(b_out_valid), 32'd1);
        @(negedge clk);
        #1;
        chk("b_beat1_datain", b_datain, 32'h00020003);
        chk("b_beat1_last", 32'(b_out_last), 32'd0);
        @(negedge clk);
        #1;
        chk("b_beat2_datain", b_datain, 32'h00040000);
        chk("b_beat2_last", 32'(b_out_last), 32'd1);
        @(negedge clk);
        #1;
        chk("b_idle_datain", b_datain, 32'd0);
        chk("b_idle_valid", 32'(b_out_valid), 32'd0);
        chk("b_idle_ready", 32'(b_row_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/systolic_diag_feeder.md
Name: systolic_diag_feeder

Overview:
Transmit side of the systolic array's activation input.
- Accepts a square N x N activation tile as N row beats over a valid/ready handshake, buffers it, then drives it onto the array's packed `datain` bus as 2N-1 anti-diagonal beats.
- Sits between the activation source (BRAM reader or controller) and `systolic_array.datain`, replacing hand-built skewed stimulus.

Parameters:
- N, 4, array dimension (rows/cols of tile, lanes of datain)
- DW, 8, element width in bits

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- row_in  input  N*DW  one tile row; column 0 in MSB element slot, column N-1 in LSB slot
- row_valid  input  1  row_in valid
- row_ready  output  1  feeder accepts a row this cycle
- datain  output  N*DW  packed anti-diagonal beat to systolic_array; slot 0 = MSB element
- out_valid  output  1  datain carries a tile beat this cycle
- out_first  output  1  high with beat 0 of a tile
- out_last  output  1  high with beat 2N-2 of a tile
- busy  output  1  high in LOAD (≥1 row accepted) or STREAM

Behaviour:
- Reset (async assert, sync deassert by user):
  - state=LOAD, row_cnt=0, beat_cnt=0.
  - datain=0, out_valid=0, out_first=0, out_last=0, busy=0, row_ready=1.
  - Tile buffer contents don't-care.
- Row accept: row_valid & row_ready at a rising edge stores row_in into buffer row row_cnt, row_cnt++.
- State LOAD:
  - row_ready=1.
  - On accept of row N-1: row_cnt←0, beat_cnt←0, go STREAM.
  - row_valid gaps are allowed; row order is strictly 0..N-1.
- State STREAM:
  - row_ready=0; row_valid is ignored and no buffer write occurs.
  - Each cycle emits beat k=beat_cnt then beat_cnt++.
  - At k=2N-2, return to LOAD next cycle.
  - No stall: exactly 2N-1 consecutive beats.
- Beat contents, registered:
  - Beat k, slot s (s=0 is MSB element) = A[r][k-r], where r = max(0,k-N+1)+s, valid while r ≤ min(k,N-1).
  - Slots past that bound are 0.
  - Example, N=4: k=0 → {A00,0,0,0}; k=3 → {A03,A12,A21,A30}; k=6 → {A33,0,0,0}.
- Latency and framing:
  - Beat 0 appears on datain/out_valid the cycle after row N-1 is accepted.
  - out_first accompanies it.
  - out_last accompanies beat 2N-2.
- Idle output: datain=0 and out_valid=0 whenever not in STREAM. The array sees zeros, not stale data.
- Back-to-back tiles:
  - Cycle after out_last, row_ready=1.
  - Minimum tile period is N + 2N-1 cycles. There is no double buffering.
- busy = (state==STREAM) | (row_cnt != 0).
- Reset mid-LOAD or mid-STREAM: outputs return to their reset values immediately (asynchronous). Partial tile is discarded; no further beats are emitted.
- Arithmetic: row_cnt is clog2(N) bits; beat_cnt is clog2(2N-1) bits, with no wrap beyond 2N-2. Elements pass through unmodified (no sign/width change).

Decomposition:
- Shared package `systolic_pkg`: N, DW, state enum {LOAD, STREAM}, helper function returning first row index max(0,k-N+1).
- One sub-module: `diag_select`, combinational. Takes the buffer array and k, produces the packed beat with zero fill. The top registers its output.

Test Plan:
- Baseline N=4, tile A = 1..16 enumerated along anti-diagonals (rows 01020407, 0305080B, 06090C0E, 0A0D0F10), row_valid held high → row_ready high 4 cycles; then datain = 01000000, 02030000, 04050600, 0708090A, 0B0C0D00, 0E0F0000, 10000000 on 7 consecutive cycles. out_first on the 1st beat, out_last on the 7th, then datain=0 and out_valid=0.
- Gapped load: same rows with row_valid low 2 cycles between rows → identical beat sequence; beat 0 appears exactly one cycle after the 4th accept.
- Load during stream: row_valid=1 with row_in=FFFFFFFF during STREAM → row_ready=0; buffer unchanged; next tile loads normally after out_last.
- Back-to-back tiles: second tile (all 0x11) starts loading the cycle after out_last → beats 11000000, 11110000, 11111100, 11111111, 11111100, 11110000, 11000000.
- Reset mid-stream: assert reset=0 during beat 3 → datain=0, out_valid=0, busy=0 in the same cycle. After release, a fresh full tile is required before any beat.
- Parameter N=2, DW=16, rows {0001,0002},{0003,0004} → beats {0001,0000}, {0002,0003}, {0004,0000}.
